// File: rtl/add_mul_frame_accumulator.sv
// Frame accumulator behind the 4-bit add/multiply datapath: sums products and sums
// over a frame closed by in_last or by the sample-count limit, then holds the totals.
module add_mul_frame_accumulator #(
  parameter int MUL_ACC_W = 16,
  parameter int ADD_ACC_W = 12,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [7:0]           mul_in,
  input  logic [3:0]           add_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MUL_ACC_W-1:0] acc_mul,
  output logic [ADD_ACC_W-1:0] acc_add,
  output logic [CNT_W-1:0]     count,
  output logic                 sat,
  output logic                 len_ovf,
  output logic [1:0]           state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and valid/data stay stable until the transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  state_t                 state_q;
  logic [MUL_ACC_W-1:0]   acc_mul_q, acc_mul_d;
  logic [ADD_ACC_W-1:0]   acc_add_q, acc_add_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   sat_q, len_ovf_q, out_valid_q, in_ready_q;
  logic [MUL_ACC_W:0]     mul_sum;
  logic [ADD_ACC_W:0]     add_sum;
  logic                   accept, at_limit, close;

  // One extra carry bit detects overflow; on overflow the accumulator pins at all-ones.
  assign mul_sum   = {1'b0, acc_mul_q} + (MUL_ACC_W+1)'(mul_in);
  assign add_sum   = {1'b0, acc_add_q} + (ADD_ACC_W+1)'(add_in);
  assign acc_mul_d = mul_sum[MUL_ACC_W] ? '1 : mul_sum[MUL_ACC_W-1:0];
  assign acc_add_d = add_sum[ADD_ACC_W] ? '1 : add_sum[ADD_ACC_W-1:0];
  assign count_d   = count_q + CNT_W'(1);
  assign at_limit  = (count_d == '1);
  assign accept    = in_valid & in_ready_q;
  assign close     = in_last | at_limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_mul_q   <= '0;
      acc_add_q   <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      len_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_mul_q <= acc_mul_d;
            acc_add_q <= acc_add_d;
            count_q   <= count_d;
            sat_q     <= sat_q | mul_sum[MUL_ACC_W] | add_sum[ADD_ACC_W];
            if (close) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              len_ovf_q   <= at_limit & ~in_last;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_mul_q   <= '0;
            acc_add_q   <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            len_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_mul   = acc_mul_q;
  assign acc_add   = acc_add_q;
  assign count     = count_q;
  assign sat       = sat_q;
  assign len_ovf   = len_ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_add_mul_frame_accumulator.sv
// Bench for add_mul_frame_accumulator: a default-sized instance and a narrow one
// (8-bit product acc, 4-bit sum acc, 2-bit counter) share one input stream.
module tb_add_mul_frame_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_last, out_ready;
  logic [7:0]  mul_in;
  logic [3:0]  add_in;

  logic        b_in_ready, b_out_valid, b_sat, b_len_ovf;
  logic [15:0] b_acc_mul;
  logic [11:0] b_acc_add;
  logic [7:0]  b_count;
  logic [1:0]  b_state;

  logic        s_in_ready, s_out_valid, s_sat, s_len_ovf;
  logic [7:0]  s_acc_mul;
  logic [3:0]  s_acc_add;
  logic [1:0]  s_count;
  logic [1:0]  s_state;

  add_mul_frame_accumulator u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .mul_in(mul_in), .add_in(add_in), .out_valid(b_out_valid),
    .out_ready(out_ready), .acc_mul(b_acc_mul), .acc_add(b_acc_add), .count(b_count),
    .sat(b_sat), .len_ovf(b_len_ovf), .state_dbg(b_state)
  );

  add_mul_frame_accumulator #(.MUL_ACC_W(8), .ADD_ACC_W(4), .CNT_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_last(in_last), .mul_in(mul_in), .add_in(add_in), .out_valid(s_out_valid),
    .out_ready(out_ready), .acc_mul(s_acc_mul), .acc_add(s_acc_add), .count(s_count),
    .sat(s_sat), .len_ovf(s_len_ovf), .state_dbg(s_state)
  );

  typedef struct {
    bit     hold;
    longint mul;
    longint add;
    longint cnt;
    bit     sat;
    bit     ovf;
  } mstate_t;

  typedef struct {
    bit iv; bit il; int m; int a; bit ordy;
    bit e_rdy; bit e_ov; int e_mul; int e_add; int e_cnt; bit e_sat; bit e_ovf;
  } vec_t;

  mstate_t     mb, ms;
  vec_t        vecs[11];
  logic [35:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Frame-level reference: totals saturate at the accumulator maximum, a frame closes
  // on in_last or when the count reaches 2^cw-1, and a closed frame waits for out_ready.
  function automatic mstate_t model_next(mstate_t s, int mw, int aw, int cw, bit rn,
                                         bit iv, bit il, int mi, int ai, bit ordy);
    mstate_t r;
    longint  mmax, amax, lim;
    r    = s;
    mmax = (longint'(1) << mw) - 1;
    amax = (longint'(1) << aw) - 1;
    lim  = (longint'(1) << cw) - 1;
    if (!rn) begin
      r = '{default: 0};
    end else if (s.hold) begin
      if (ordy) r = '{default: 0};
    end else if (iv) begin
      if (s.mul + mi > mmax) begin r.mul = mmax; r.sat = 1; end
      else r.mul = s.mul + mi;
      if (s.add + ai > amax) begin r.add = amax; r.sat = 1; end
      else r.add = s.add + ai;
      r.cnt = s.cnt + 1;
      if (il || r.cnt == lim) begin
        r.hold = 1;
        r.ovf  = !il;
      end
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(string p, logic rdy, logic ov, logic [63:0] m, logic [63:0] a,
                          logic [63:0] c, logic st, logic of, mstate_t e);
    chk({p, "_in_ready"},  64'(rdy), 64'(!e.hold));
    chk({p, "_out_valid"}, 64'(ov),  64'(e.hold));
    chk({p, "_acc_mul"},   m,        64'(e.mul));
    chk({p, "_acc_add"},   a,        64'(e.add));
    chk({p, "_count"},     c,        64'(e.cnt));
    chk({p, "_sat"},       64'(st),  64'(e.sat));
    chk({p, "_len_ovf"},   64'(of),  64'(e.ovf));
  endtask

  task automatic drive(bit iv, bit il, int m, int a, bit ordy);
    in_valid  = iv;
    in_last   = il;
    mul_in    = 8'(m);
    add_in    = 4'(a);
    out_ready = ordy;
  endtask

  // Advance one clock: settle the scoreboard on any output handshake, advance both
  // models, then compare every output 1 time unit after the edge.
  task automatic step();
    mstate_t nb, ns;
    logic [35:0] got, want;
    if (rst_n && b_out_valid && out_ready) begin
      got = {b_acc_mul, b_acc_add, b_count};
      if (exp_q.size() == 0) chk("sb_unexpected_frame", 64'(got), 64'(0));
      else begin
        want = exp_q.pop_front();
        chk("sb_frame_totals", 64'(got), 64'(want));
      end
    end
    nb = model_next(mb, 16, 12, 8, rst_n, in_valid, in_last, int'(mul_in), int'(add_in), out_ready);
    ns = model_next(ms, 8, 4, 2, rst_n, in_valid, in_last, int'(mul_in), int'(add_in), out_ready);
    if (!rst_n) exp_q.delete();
    else if (!mb.hold && nb.hold) exp_q.push_back({16'(nb.mul), 12'(nb.add), 8'(nb.cnt)});
    mb = nb;
    ms = ns;
    @(posedge clk);
    #1;
    cmp_inst("big", b_in_ready, b_out_valid, 64'(b_acc_mul), 64'(b_acc_add), 64'(b_count),
             b_sat, b_len_ovf, mb);
    cmp_inst("small", s_in_ready, s_out_valid, 64'(s_acc_mul), 64'(s_acc_add), 64'(s_count),
             s_sat, s_len_ovf, ms);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    mb = '{default: 0};
    ms = '{default: 0};
    vecs[0]  = '{1, 0,   6,  5, 0,  1, 0,   6,  5, 1, 0, 0};
    vecs[1]  = '{1, 0, 225, 14, 0,  1, 0, 231, 19, 2, 0, 0};
    vecs[2]  = '{1, 1,   1,  0, 0,  0, 1, 232, 19, 3, 0, 0};
    for (int i = 3; i < 8; i++) vecs[i] = '{1, 1, 7, 2, 0,  0, 1, 232, 19, 3, 0, 0};
    vecs[8]  = '{1, 1,   7,  2, 1,  1, 0,   0,  0, 0, 0, 0};
    vecs[9]  = '{1, 1,   7,  2, 0,  0, 1,   7,  2, 1, 0, 0};
    vecs[10] = '{0, 0,   0,  0, 1,  1, 0,   0,  0, 0, 0, 0};

    rst_n = 1'b0;
    drive(1, 1, 33, 4, 1);
    step();
    do_reset();
    chk("rst_in_ready",  64'(b_in_ready),  64'(1));
    chk("rst_out_valid", 64'(b_out_valid), 64'(0));
    chk("rst_acc_mul",   64'(b_acc_mul),   64'(0));
    chk("rst_count",     64'(b_count),     64'(0));

    // Basic frame then backpressure with a pending pair.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].iv, vecs[i].il, vecs[i].m, vecs[i].a, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d_in_ready", i),  64'(b_in_ready),  64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 64'(b_out_valid), 64'(vecs[i].e_ov));
      chk($sformatf("vec%0d_acc_mul", i),   64'(b_acc_mul),   64'(vecs[i].e_mul));
      chk($sformatf("vec%0d_acc_add", i),   64'(b_acc_add),   64'(vecs[i].e_add));
      chk($sformatf("vec%0d_count", i),     64'(b_count),     64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_sat", i),       64'(b_sat),       64'(vecs[i].e_sat));
      chk($sformatf("vec%0d_len_ovf", i),   64'(b_len_ovf),   64'(vecs[i].e_ovf));
    end

    // Saturation on the narrow product accumulator.
    do_reset();
    drive(1, 0, 200, 0, 0); step();
    drive(1, 1, 100, 0, 0); step();
    chk("sat_acc_mul",   64'(s_acc_mul),   64'(255));
    chk("sat_flag",      64'(s_sat),       64'(1));
    chk("sat_count",     64'(s_count),     64'(2));
    chk("sat_out_valid", 64'(s_out_valid), 64'(1));

    // Length limit on the 2-bit counter, with a fourth pair held off until drain.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1, 0, 10, 1, 0); step(); end
    chk("len_count",     64'(s_count),     64'(3));
    chk("len_ovf_flag",  64'(s_len_ovf),   64'(1));
    chk("len_out_valid", 64'(s_out_valid), 64'(1));
    for (int i = 0; i < 2; i++) begin drive(1, 0, 4, 4, 0); step(); end
    chk("len_held_ready", 64'(s_in_ready), 64'(0));
    chk("len_held_count", 64'(s_count),    64'(3));
    drive(1, 0, 4, 4, 1); step();
    chk("len_drain_count", 64'(s_count), 64'(0));
    drive(1, 0, 4, 4, 0); step();
    chk("len_next_count", 64'(s_count),   64'(1));
    chk("len_next_mul",   64'(s_acc_mul), 64'(4));

    // Reset mid-frame, then a single-pair frame.
    do_reset();
    drive(1, 0, 50, 7, 0); step();
    drive(1, 0, 60, 8, 0); step();
    rst_n = 1'b0;
    drive(1, 0, 70, 9, 0); step();
    rst_n = 1'b1;
    chk("mid_rst_acc_mul",  64'(b_acc_mul),  64'(0));
    chk("mid_rst_count",    64'(b_count),    64'(0));
    chk("mid_rst_in_ready", 64'(b_in_ready), 64'(1));
    drive(1, 1, 9, 3, 0); step();
    chk("single_acc_mul",   64'(b_acc_mul),   64'(9));
    chk("single_acc_add",   64'(b_acc_add),   64'(3));
    chk("single_count",     64'(b_count),     64'(1));
    chk("single_out_valid", 64'(b_out_valid), 64'(1));

    // Stalled frame: three idle input cycles between pairs.
    do_reset();
    drive(1, 0, 10, 1, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 99, 9, 0); step(); end
    drive(1, 0, 20, 2, 0); step();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 99, 9, 0); step(); end
    drive(1, 1, 30, 3, 0); step();
    chk("stall_acc_mul", 64'(b_acc_mul), 64'(60));
    chk("stall_acc_add", 64'(b_acc_add), 64'(6));
    chk("stall_count",   64'(b_count),   64'(3));
    drive(0, 0, 0, 0, 1); step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
            int'($urandom_range(0, 225)), int'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 6);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_mul_frame_accumulator.md
# add_mul_frame_accumulator

Downstream consumer of the 4-bit add/multiply combinational datapath. Accepts one (product, sum) result pair per handshake, accumulates products and sums over a frame delimited by `in_last`, then presents the frame totals, sample count and status flags on a valid/ready output port. Decouples the combinational stage from the downstream consumer and absorbs output backpressure.

## Interface
- `MUL_ACC_W`, default 16: product accumulator width; minimum 8.
- `ADD_ACC_W`, default 12: sum accumulator width; minimum 4.
- `CNT_W`, default 8: sample counter width; maximum frame length is 2^CNT_W − 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active-low, sampled on the rising edge of `clk`.
- `in_valid`  in  1  upstream pair is valid.
- `in_ready`  out  1  block can accept a pair this cycle.
- `in_last`  in  1  qualifies the final pair of the frame.
- `mul_in`  in  8  product from the multiplier (Result_mul).
- `add_in`  in  4  sum from the adder (Result_add).
- `out_valid`  out  1  frame totals valid.
- `out_ready`  in  1  downstream accepts the totals.
- `acc_mul`  out  MUL_ACC_W  saturating sum of `mul_in` over the frame.
- `acc_add`  out  ADD_ACC_W  saturating sum of `add_in` over the frame.
- `count`  out  CNT_W  number of pairs in the frame.
- `sat`  out  1  either accumulator saturated during the frame.
- `len_ovf`  out  1  frame was closed by counter limit, not by `in_last`.

## Operation
- FSM states: IDLE, ACCUM, HOLD.
- Reset: state IDLE. `acc_mul`, `acc_add`, `count`, `sat`, `len_ovf` are 0. `out_valid` is 0. `in_ready` is 1.
- `in_ready` = 1 in IDLE and ACCUM, 0 in HOLD. It is decoded from the registered state and does not depend combinationally on `in_valid`.
- Accept = `in_valid` & `in_ready`. On accept:
  - `acc_mul` += zero-extended `mul_in`; `acc_add` += zero-extended `add_in`; `count` += 1.
  - Transition: IDLE→ACCUM, or stay in ACCUM.
- Saturation:
  - If an addition would exceed the all-ones value, the accumulator holds all-ones and `sat` is set.
  - `sat` is sticky until the frame is drained.
- Frame close: on accept, the frame closes if `in_last` = 1 or the new `count` equals 2^CNT_W − 1. The next state is HOLD.
- `len_ovf` is set when a frame closes on the counter limit with `in_last` = 0. A pair that hits the limit with `in_last` = 1 does not set `len_ovf`.
- HOLD: `out_valid` = 1. All outputs are held stable until `out_ready` = 1.
- Drain: on `out_valid` & `out_ready`, the next state is IDLE and all accumulators, `count` and flags clear to 0.
- No accept is possible in the drain cycle, because `in_ready` is 0 in HOLD.
- `in_valid` = 0 in IDLE or ACCUM: no state change. A frame may stall indefinitely between pairs.
- Reset asserted in any state, including mid-frame or in HOLD: next edge returns to the reset values. Partial totals are discarded and no output handshake occurs.

## Timing
- Accept at edge N: totals include that pair from cycle N+1.
- Closing pair accepted at edge N: `out_valid` = 1 from cycle N+1 with final totals; `in_ready` = 0 from cycle N+1.
- Output handshake at edge M: `out_valid` = 0 and `in_ready` = 1 from cycle M+1. The first pair of the next frame can be accepted at edge M+1.
- Sustained throughput: one pair per cycle within a frame. Frame turnaround costs at least one idle input cycle (the HOLD cycle).
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Basic frame.** Default parameters. Pairs (mul 6, add 5), (225, 14), (1, 0 with `in_last`), back-to-back. Required: `out_valid` one cycle after the third accept; `acc_mul` = 232, `acc_add` = 19, `count` = 3, `sat` = 0, `len_ovf` = 0.
- **Backpressure.** After the basic frame, hold `out_ready` = 0 for 5 cycles while `in_valid` = 1. Required: outputs stable and `in_ready` = 0 throughout. When `out_ready` = 1, the drain happens and the pending pair is accepted on the following edge.
- **Saturation.** `MUL_ACC_W` = 8. Pairs (mul 200), (100 with `in_last`). Required: `acc_mul` = 255, `sat` = 1, `count` = 2.
- **Length limit.** `CNT_W` = 2. Three pairs with `in_last` = 0. Required: frame closes after the third accept with `count` = 3 and `len_ovf` = 1. A fourth pair is held off until the drain.
- **Reset mid-frame.** Accept 2 pairs, then assert `rst_n` = 0 for 1 cycle. Required: all outputs return to reset values and `in_ready` = 1. A new single-pair frame (9, 3, `in_last`) yields `acc_mul` = 9, `acc_add` = 3, `count` = 1.
- **Single-pair and stalled frames.** A frame with `in_last` on its first pair, plus a frame with 3-cycle `in_valid` gaps between pairs. Required: correct totals; no spurious accepts during gaps.
